// File: rtl/accum_done_join.sv
`default_nettype none
// ============================================================================
// Module   : accum_done_join
// Purpose  : Registered join of per-channel accumulator done pulses, with
//            two-deep per-channel capture, duplicate detection and a timeout.
// Revision : 1.0 - initial release
// ============================================================================
module accum_done_join #(
    parameter int N_CH      = 4,
    parameter int TIMEOUT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [N_CH-1:0]      ch_mask,
    input  logic [N_CH-1:0]      ch_done,
    input  logic [TIMEOUT_W-1:0] timeout_cfg,
    output logic                 all_valid,
    input  logic                 all_ready,
    output logic [N_CH-1:0]      pending,
    output logic                 dup_err,
    output logic                 timeout_err
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_HOLD    = 2'd2
    } state_t;

    localparam logic [TIMEOUT_W-1:0] c_cnt_one = {{(TIMEOUT_W-1){1'b0}}, 1'b1};
    localparam logic [TIMEOUT_W-1:0] c_cnt_max = '1;

    state_t                r_state;
    logic [N_CH-1:0]       r_mask;
    logic [N_CH-1:0]       r_pending;
    logic [N_CH-1:0]       r_next;
    logic [TIMEOUT_W-1:0]  r_count;
    logic                  r_all_valid;
    logic                  r_dup_err;
    logic                  r_timeout_err;

    logic [N_CH-1:0]       w_pulse;
    logic [N_CH-1:0]       w_to_pend;
    logic [N_CH-1:0]       w_to_next;
    logic [N_CH-1:0]       w_drop;
    logic [N_CH-1:0]       w_pend_nxt;
    logic [TIMEOUT_W-1:0]  w_cfg_last;
    logic                  w_complete;
    logic                  w_timeout;
    logic                  w_handshake;

    // In HOLD every masked pending bit is already set, so the same
    // first-slot / second-slot / drop split serves both COLLECT and HOLD.
    assign w_pulse     = ch_done & r_mask;
    assign w_to_pend   = w_pulse & ~r_pending;
    assign w_to_next   = w_pulse & r_pending & ~r_next;
    assign w_drop      = w_pulse & r_pending & r_next;
    assign w_pend_nxt  = r_pending | w_to_pend;
    assign w_complete  = ((w_pend_nxt & r_mask) == r_mask);
    assign w_cfg_last  = timeout_cfg - c_cnt_one;
    assign w_timeout   = (timeout_cfg != '0) && (r_count == w_cfg_last);
    assign w_handshake = r_all_valid & all_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_mask        <= '0;
            r_pending     <= '0;
            r_next        <= '0;
            r_count       <= '0;
            r_all_valid   <= 1'b0;
            r_dup_err     <= 1'b0;
            r_timeout_err <= 1'b0;
        end else if (start) begin
            r_state       <= S_COLLECT;
            r_mask        <= ch_mask;
            r_pending     <= '0;
            r_next        <= '0;
            r_count       <= '0;
            r_all_valid   <= 1'b0;
            r_dup_err     <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            case (r_state)
                S_COLLECT: begin
                    if (|w_drop) begin
                        r_dup_err <= 1'b1;
                    end
                    if (r_count != c_cnt_max) begin
                        r_count <= r_count + c_cnt_one;
                    end
                    // Completion takes precedence over a coincident timeout.
                    if (w_complete) begin
                        r_pending   <= w_pend_nxt;
                        r_next      <= r_next | w_to_next;
                        r_all_valid <= 1'b1;
                        r_state     <= S_HOLD;
                    end else if (w_timeout) begin
                        r_pending     <= '0;
                        r_next        <= '0;
                        r_timeout_err <= 1'b1;
                        r_state       <= S_IDLE;
                    end else begin
                        r_pending <= w_pend_nxt;
                        r_next    <= r_next | w_to_next;
                    end
                end
                S_HOLD: begin
                    if (|w_drop) begin
                        r_dup_err <= 1'b1;
                    end
                    if (w_handshake) begin
                        // Carried bits seed the next round; a fully covered
                        // mask re-completes on the following COLLECT cycle.
                        r_pending   <= r_next | w_pulse;
                        r_next      <= '0;
                        r_count     <= '0;
                        r_all_valid <= 1'b0;
                        r_state     <= S_COLLECT;
                    end else begin
                        r_next <= r_next | w_to_next;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign all_valid   = r_all_valid;
    assign pending     = r_pending;
    assign dup_err     = r_dup_err;
    assign timeout_err = r_timeout_err;

endmodule
`default_nettype wire

// File: tb/tb_accum_done_join.sv
`default_nettype none
// ============================================================================
// Module   : tb_accum_done_join
// Purpose  : Vector table, directed corner sequences and random stimulus
//            against a per-channel occupancy-count reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_accum_done_join;

    localparam int N_CH      = 4;
    localparam int TIMEOUT_W = 16;

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic                 start = 1'b0;
    logic [N_CH-1:0]      ch_mask = '0;
    logic [N_CH-1:0]      ch_done = '0;
    logic [TIMEOUT_W-1:0] timeout_cfg = '0;
    logic                 all_ready = 1'b0;
    logic                 all_valid;
    logic [N_CH-1:0]      pending;
    logic                 dup_err;
    logic                 timeout_err;

    int total = 0;
    int bad   = 0;

    accum_done_join #(.N_CH(N_CH), .TIMEOUT_W(TIMEOUT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .ch_mask     (ch_mask),
        .ch_done     (ch_done),
        .timeout_cfg (timeout_cfg),
        .all_valid   (all_valid),
        .all_ready   (all_ready),
        .pending     (pending),
        .dup_err     (dup_err),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1);
    end

    // Reference model: each channel holds 0, 1 or 2 captured pulses.
    int         m_phase;   // 0 idle, 1 collecting, 2 holding
    int         m_cnt [N_CH];
    bit [3:0]   m_mask;
    int         m_age;
    bit         m_valid, m_dup, m_to;

    task automatic model_clear();
        m_phase = 0; m_mask = '0; m_age = 0;
        m_valid = 0; m_dup = 0; m_to = 0;
        for (int i = 0; i < N_CH; i++) m_cnt[i] = 0;
    endtask

    task automatic model_edge();
        bit complete;
        if (rst) begin
            model_clear();
        end else if (start) begin
            m_mask = ch_mask; m_age = 0; m_dup = 0; m_to = 0; m_valid = 0; m_phase = 1;
            for (int i = 0; i < N_CH; i++) m_cnt[i] = 0;
        end else if (m_phase == 1) begin
            for (int i = 0; i < N_CH; i++)
                if (m_mask[i] && ch_done[i]) begin
                    if (m_cnt[i] < 2) m_cnt[i]++;
                    else m_dup = 1;
                end
            complete = 1;
            for (int i = 0; i < N_CH; i++)
                if (m_mask[i] && m_cnt[i] == 0) complete = 0;
            if (complete) begin
                m_phase = 2; m_valid = 1;
            end else if (timeout_cfg != 0 && m_age == int'(timeout_cfg) - 1) begin
                m_to = 1; m_phase = 0;
                for (int i = 0; i < N_CH; i++) m_cnt[i] = 0;
            end
            m_age++;
        end else if (m_phase == 2) begin
            if (all_ready) begin
                for (int i = 0; i < N_CH; i++)
                    if (m_mask[i]) begin
                        if (ch_done[i] && m_cnt[i] == 2) m_dup = 1;
                        m_cnt[i] = (m_cnt[i] == 2 || ch_done[i]) ? 1 : 0;
                    end
                m_phase = 1; m_valid = 0; m_age = 0;
            end else begin
                for (int i = 0; i < N_CH; i++)
                    if (m_mask[i] && ch_done[i]) begin
                        if (m_cnt[i] < 2) m_cnt[i]++;
                        else m_dup = 1;
                    end
            end
        end
    endtask

    function automatic logic [7:0] model_vec();
        logic [3:0] p;
        for (int i = 0; i < N_CH; i++) p[i] = (m_cnt[i] >= 1);
        return {1'b0, m_to, m_dup, m_valid, p};
    endfunction

    function automatic logic [7:0] dut_vec();
        return {1'b0, timeout_err, dup_err, all_valid, pending};
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got {to,dup,valid,pend}=%h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check("model", dut_vec(), model_vec());
    endtask

    task automatic drive(input bit r, input bit s, input logic [3:0] m, input logic [3:0] d,
                         input bit rdy);
        rst = r; start = s; ch_mask = m; ch_done = d; all_ready = rdy;
    endtask

    function automatic logic [7:0] ev(input bit v, input logic [3:0] p, input bit d, input bit t);
        return {1'b0, t, d, v, p};
    endfunction

    typedef struct {
        bit         rst;
        bit         start;
        logic [3:0] mask;
        logic [3:0] done;
        bit         ready;
        logic [7:0] exp;
    } vec_t;

    vec_t tbl [$];

    function automatic vec_t mk(input bit r, input bit s, input logic [3:0] m,
                                input logic [3:0] d, input bit rdy, input logic [7:0] e);
        vec_t x;
        x.rst = r; x.start = s; x.mask = m; x.done = d; x.ready = rdy; x.exp = e;
        return x;
    endfunction

    initial begin
        model_clear();
        timeout_cfg = '0;

        // Join in arbitrary order, partial masks, and ch0 overrun.
        tbl.push_back(mk(1, 0, 4'hF, 4'h0, 0, ev(0, 4'h0, 0, 0)));
        tbl.push_back(mk(0, 1, 4'hF, 4'h0, 0, ev(0, 4'h0, 0, 0)));
        tbl.push_back(mk(0, 0, 4'hF, 4'h0, 0, ev(0, 4'h0, 0, 0)));
        tbl.push_back(mk(0, 0, 4'hF, 4'h1, 0, ev(0, 4'h1, 0, 0)));
        tbl.push_back(mk(0, 0, 4'hF, 4'h0, 0, ev(0, 4'h1, 0, 0)));
        tbl.push_back(mk(0, 0, 4'hF, 4'h6, 0, ev(0, 4'h7, 0, 0)));
        tbl.push_back(mk(0, 0, 4'hF, 4'h8, 0, ev(1, 4'hF, 0, 0)));
        tbl.push_back(mk(0, 0, 4'hF, 4'h0, 1, ev(0, 4'h0, 0, 0)));
        tbl.push_back(mk(0, 1, 4'h5, 4'h0, 0, ev(0, 4'h0, 0, 0)));
        tbl.push_back(mk(0, 0, 4'hF, 4'hA, 0, ev(0, 4'h0, 0, 0)));
        tbl.push_back(mk(0, 0, 4'hF, 4'h5, 0, ev(1, 4'h5, 0, 0)));
        tbl.push_back(mk(0, 0, 4'hF, 4'h1, 0, ev(1, 4'h5, 0, 0)));
        tbl.push_back(mk(0, 0, 4'hF, 4'h1, 0, ev(1, 4'h5, 1, 0)));
        tbl.push_back(mk(0, 0, 4'hF, 4'h0, 1, ev(0, 4'h1, 1, 0)));
        tbl.push_back(mk(0, 0, 4'hF, 4'h0, 0, ev(0, 4'h1, 1, 0)));
        tbl.push_back(mk(0, 1, 4'hF, 4'h0, 0, ev(0, 4'h0, 0, 0)));
        tbl.push_back(mk(0, 0, 4'hF, 4'h1, 0, ev(0, 4'h1, 0, 0)));
        tbl.push_back(mk(0, 0, 4'hF, 4'h1, 0, ev(0, 4'h1, 0, 0)));
        tbl.push_back(mk(0, 0, 4'hF, 4'h1, 0, ev(0, 4'h1, 1, 0)));
        tbl.push_back(mk(0, 0, 4'hF, 4'hE, 0, ev(1, 4'hF, 1, 0)));
        tbl.push_back(mk(0, 0, 4'hF, 4'h0, 1, ev(0, 4'h1, 1, 0)));

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].rst, tbl[i].start, tbl[i].mask, tbl[i].done, tbl[i].ready);
            step();
            check($sformatf("vec%0d", i), dut_vec(), tbl[i].exp);
        end

        // Back-to-back join: all channels re-report while HOLD waits on ready.
        drive(0, 1, 4'hF, 4'h0, 0); step();
        drive(0, 0, 4'hF, 4'hF, 0); step();
        check("b2b_hold", dut_vec(), ev(1, 4'hF, 0, 0));
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 4'hF, (i == 1) ? 4'hF : 4'h0, 0); step();
        end
        check("b2b_held", dut_vec(), ev(1, 4'hF, 0, 0));
        drive(0, 0, 4'hF, 4'h0, 1); step();
        check("b2b_accept", dut_vec(), ev(0, 4'hF, 0, 0));
        drive(0, 0, 4'hF, 4'h0, 0); step();
        check("b2b_again", dut_vec(), ev(1, 4'hF, 0, 0));
        drive(0, 0, 4'hF, 4'h0, 1); step();

        // Timeout after exactly timeout_cfg collect cycles.
        timeout_cfg = 16'd8;
        drive(0, 1, 4'hF, 4'h0, 0); step();
        for (int k = 1; k <= 8; k++) begin
            drive(0, 0, 4'hF, (k == 1) ? 4'h1 : 4'h0, 0); step();
            if (k == 7) check("to_before", dut_vec(), ev(0, 4'h1, 0, 0));
            if (k == 8) check("to_fire", dut_vec(), ev(0, 4'h0, 0, 1));
        end
        drive(0, 0, 4'hF, 4'hF, 1); step();
        check("to_idle", dut_vec(), ev(0, 4'h0, 0, 1));
        timeout_cfg = 16'd0;
        drive(0, 1, 4'hF, 4'h0, 0); step();
        check("to_cleared", dut_vec(), ev(0, 4'h0, 0, 0));
        drive(0, 0, 4'hF, 4'h1, 0); step();
        for (int k = 0; k < 1000; k++) begin
            drive(0, 0, 4'hF, 4'h0, 0); step();
        end
        check("to_disabled", dut_vec(), ev(0, 4'h1, 0, 0));

        // Reset one cycle before completion, then empty-mask join.
        drive(0, 1, 4'hF, 4'h0, 0); step();
        drive(0, 0, 4'hF, 4'h7, 0); step();
        drive(1, 0, 4'hF, 4'h8, 0); step();
        check("rst_mid", dut_vec(), ev(0, 4'h0, 0, 0));
        drive(0, 0, 4'hF, 4'hF, 1); step();
        check("rst_idle", dut_vec(), ev(0, 4'h0, 0, 0));
        drive(0, 1, 4'h0, 4'h0, 0); step();
        check("mask0_start", dut_vec(), ev(0, 4'h0, 0, 0));
        drive(0, 0, 4'h0, 4'hF, 0); step();
        check("mask0_join", dut_vec(), ev(1, 4'h0, 0, 0));

        // Random traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            rst       = ($urandom_range(0, 99) == 0);
            start     = ($urandom_range(0, 24) == 0);
            ch_mask   = 4'($urandom);
            ch_done   = 4'($urandom & $urandom);
            all_ready = ($urandom_range(0, 2) == 0);
            if (start) timeout_cfg = 16'($urandom_range(0, 12));
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
